// File: rtl/singlecycle_pkg.sv
// Shared types and constants for the LSU bus arbiter.
//   arb_state_e  : arbiter FSM state (IDLE = free to grant, LOCKED = waiting for READY)
//   BUS_ERR_DATA : load data returned to a master whose transaction timed out
package singlecycle_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker, purely combinational.
// Ports:
//   req     in   N        request vector
//   ptr     in   clog2(N) index of the highest-priority requester
//   gnt_oh  out  N        one-hot winner (zero when no request)
//   gnt_idx out  clog2(N) binary index of the winner (zero when no request)
//   any     out  1        at least one request present
module rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt_oh,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any
);

    localparam int PW = $clog2(N);
    localparam logic [2*N-1:0] ONE = {{(2*N-1){1'b0}}, 1'b1};

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] mask;
    logic [2*N-1:0] masked;
    logic [2*N-1:0] lowest;

    // The request vector is duplicated so that masking off everything below
    // ptr still leaves the wrapped-around requesters visible in the upper
    // copy. Isolating the lowest set bit then yields the round-robin winner.
    assign dbl    = {req, req};
    assign mask   = {(2*N){1'b1}} << ptr;
    assign masked = dbl & mask;
    assign lowest = masked & (~masked + ONE);
    assign gnt_oh = lowest[N-1:0] | lowest[2*N-1:N];
    assign any    = |req;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_oh[i]) gnt_idx = PW'(i);
        end
    end

endmodule

// File: rtl/lsu_bus_arbiter.sv
// Shares the single LSU VALID/READY port between N_REQ masters.
// Round-robin grant, held until the LSU returns READY; a watchdog forces a
// bus error on transactions that never complete.
// Ports:
//   i_clk, i_rst_n                clock, asynchronous active-low reset
//   i_req_valid/addr/wdata/strb/wren   per-master request payload (master k at slice k)
//   o_req_ready, o_req_err        one-hot READY / bus error back to the masters
//   o_req_rdata                   load data, shared by all masters
//   o_VALID, o_lsu_addr, o_st_data, o_st_strb, o_lsu_wren   request to the lsu
//   i_READY, i_ld_data            response from the lsu
//   o_busy                        high while a grant is locked
//
// Handshake: a transfer happens when a master's VALID and its READY are both
// high in the same cycle; masters hold VALID and payload stable until then.
module lsu_bus_arbiter
    import singlecycle_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [N_REQ-1:0]      i_req_valid,
    input  logic [N_REQ*32-1:0]   i_req_addr,
    input  logic [N_REQ*32-1:0]   i_req_wdata,
    input  logic [N_REQ*4-1:0]    i_req_strb,
    input  logic [N_REQ-1:0]      i_req_wren,
    output logic [N_REQ-1:0]      o_req_ready,
    output logic [N_REQ-1:0]      o_req_err,
    output logic [31:0]           o_req_rdata,
    output logic                  o_VALID,
    output logic [31:0]           o_lsu_addr,
    output logic [31:0]           o_st_data,
    output logic [3:0]            o_st_strb,
    output logic                  o_lsu_wren,
    input  logic                  i_READY,
    input  logic [31:0]           i_ld_data,
    output logic                  o_busy
);

    localparam int PW   = $clog2(N_REQ);
    localparam int WD_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    arb_state_e        state;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     gnt;
    logic [WD_W-1:0]   wd_cnt;

    logic [N_REQ-1:0]  win_oh;
    logic [PW-1:0]     win_idx;
    logic              win_any;
    logic [N_REQ-1:0]  gnt_oh;
    logic              gnt_valid;
    logic              timeout_hit;

    logic [N_REQ-1:0]  sel_oh;   // master whose payload reaches the lsu
    logic [N_REQ-1:0]  done_oh;  // master completing this cycle
    logic [N_REQ-1:0]  err_oh;   // master completing with a bus error

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(N_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    rr_pick #(.N(N_REQ)) u_pick (
        .req     (i_req_valid),
        .ptr     (rr_ptr),
        .gnt_oh  (win_oh),
        .gnt_idx (win_idx),
        .any     (win_any)
    );

    always_comb begin
        gnt_oh = '0;
        for (int k = 0; k < N_REQ; k++) begin
            gnt_oh[k] = (gnt == PW'(k));
        end
    end

    assign gnt_valid   = |(i_req_valid & gnt_oh);
    assign timeout_hit = (TIMEOUT_CYC != 0) && (wd_cnt == WD_W'(TIMEOUT_CYC));

    // Selection is gated by i_rst_n so every output drops to zero the moment
    // reset is asserted, even while masters keep VALID high.
    always_comb begin
        sel_oh  = '0;
        done_oh = '0;
        err_oh  = '0;
        if (i_rst_n) begin
            if (state == ARB_IDLE) begin
                sel_oh = win_oh;
                if (i_READY) done_oh = win_oh;
            end else if (gnt_valid) begin
                // READY takes precedence over a coinciding timeout.
                if (i_READY) begin
                    sel_oh  = gnt_oh;
                    done_oh = gnt_oh;
                end else if (timeout_hit) begin
                    // o_VALID stays low so no write can commit.
                    done_oh = gnt_oh;
                    err_oh  = gnt_oh;
                end else begin
                    sel_oh = gnt_oh;
                end
            end
        end
    end

    // AND-OR payload mux on the one-hot select.
    always_comb begin
        o_lsu_addr = '0;
        o_st_data  = '0;
        o_st_strb  = '0;
        o_lsu_wren = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            o_lsu_addr = o_lsu_addr | ({32{sel_oh[k]}} & i_req_addr[32*k +: 32]);
            o_st_data  = o_st_data  | ({32{sel_oh[k]}} & i_req_wdata[32*k +: 32]);
            o_st_strb  = o_st_strb  | ({4{sel_oh[k]}}  & i_req_strb[4*k +: 4]);
            o_lsu_wren = o_lsu_wren | (sel_oh[k] & i_req_wren[k]);
        end
    end

    assign o_VALID     = |sel_oh;
    assign o_req_ready = done_oh;
    assign o_req_err   = err_oh;
    assign o_req_rdata = (|err_oh)  ? BUS_ERR_DATA :
                         (|done_oh) ? i_ld_data    : 32'h0;
    assign o_busy      = (state == ARB_LOCKED);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= ARB_IDLE;
            rr_ptr <= '0;
            gnt    <= '0;
            wd_cnt <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (win_any) begin
                        if (i_READY) begin
                            rr_ptr <= next_ptr(win_idx);
                        end else begin
                            gnt    <= win_idx;
                            wd_cnt <= WD_W'(1);
                            state  <= ARB_LOCKED;
                        end
                    end
                end
                ARB_LOCKED: begin
                    if (!gnt_valid) begin
                        // Master abandoned its request: release without
                        // advancing the pointer.
                        wd_cnt <= '0;
                        state  <= ARB_IDLE;
                    end else if (i_READY || timeout_hit) begin
                        rr_ptr <= next_ptr(gnt);
                        wd_cnt <= '0;
                        state  <= ARB_IDLE;
                    end else if (wd_cnt != '1) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_arbiter.sv
module tb_lsu_bus_arbiter;

    localparam int N  = 2;
    localparam int TO = 4;
    localparam logic [31:0] LEDR_ADDR = 32'hFF20_0000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N*32-1:0]   req_addr;
    logic [N*32-1:0]   req_wdata;
    logic [N*4-1:0]    req_strb;
    logic [N-1:0]      req_wren;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_err;
    logic [31:0]       req_rdata;
    logic              lsu_valid;
    logic [31:0]       lsu_addr;
    logic [31:0]       st_data;
    logic [3:0]        st_strb;
    logic              lsu_wren;
    logic              ready_in;
    logic [31:0]       ld_data;
    logic              busy;

    lsu_bus_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .i_req_strb  (req_strb),
        .i_req_wren  (req_wren),
        .o_req_ready (req_ready),
        .o_req_err   (req_err),
        .o_req_rdata (req_rdata),
        .o_VALID     (lsu_valid),
        .o_lsu_addr  (lsu_addr),
        .o_st_data   (st_data),
        .o_st_strb   (st_strb),
        .o_lsu_wren  (lsu_wren),
        .i_READY     (ready_in),
        .i_ld_data   (ld_data),
        .o_busy      (busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- counters / scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // Reference model: owner of the port (-1 = free), cycles spent in the
    // current transaction, and the round-robin start index.
    int own = -1;
    int age = 0;
    int rr  = 0;
    int m_sel;

    logic [N-1:0] e_ready, e_err;
    logic [31:0]  e_rdata, e_addr, e_wdata;
    logic [3:0]   e_strb;
    logic         e_wren, e_valid, e_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_eval();
        e_ready = '0; e_err = '0; e_rdata = '0; e_valid = 1'b0;
        e_addr = '0; e_wdata = '0; e_strb = '0; e_wren = 1'b0;
        e_busy = (own >= 0);
        m_sel = -1;
        if (own < 0) begin
            for (int j = 0; j < N; j++) begin
                int k;
                k = (rr + j) % N;
                if (req_valid[k] && m_sel < 0) m_sel = k;
            end
            if (m_sel >= 0) begin
                e_valid = 1'b1;
                if (ready_in) begin
                    e_ready[m_sel] = 1'b1;
                    e_rdata = ld_data;
                end
            end
        end else if (req_valid[own]) begin
            if (ready_in) begin
                m_sel = own;
                e_valid = 1'b1;
                e_ready[own] = 1'b1;
                e_rdata = ld_data;
            end else if (TO != 0 && age == TO) begin
                e_ready[own] = 1'b1;
                e_err[own] = 1'b1;
                e_rdata = 32'hDEAD_BEEF;
            end else begin
                m_sel = own;
                e_valid = 1'b1;
            end
        end
        if (e_valid) begin
            e_addr  = req_addr[32*m_sel +: 32];
            e_wdata = req_wdata[32*m_sel +: 32];
            e_strb  = req_strb[4*m_sel +: 4];
            e_wren  = req_wren[m_sel];
        end
    endtask

    task automatic model_commit();
        if (own < 0) begin
            if (m_sel >= 0) begin
                if (ready_in) rr = (m_sel + 1) % N;
                else begin own = m_sel; age = 1; end
            end
        end else if (!req_valid[own]) begin
            own = -1;
        end else if (ready_in || (TO != 0 && age == TO)) begin
            rr = (own + 1) % N;
            own = -1;
        end else begin
            age++;
        end
    endtask

    task automatic compare();
        chk("busy",  32'(busy),      32'(e_busy));
        chk("ready", 32'(req_ready), 32'(e_ready));
        chk("err",   32'(req_err),   32'(e_err));
        chk("valid", 32'(lsu_valid), 32'(e_valid));
        if (e_ready != '0) exp_q.push_back(e_rdata);
        if (req_ready != '0 && exp_q.size() > 0) chk("rdata", req_rdata, exp_q.pop_front());
        if (e_valid || req_valid == '0) begin
            chk("addr",  lsu_addr,       e_addr);
            chk("wdata", st_data,        e_wdata);
            chk("strb",  32'(st_strb),   32'(e_strb));
            chk("wren",  32'(lsu_wren),  32'(e_wren));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int k, input logic v, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s, input logic w);
        req_valid[k]        = v;
        req_addr[32*k +: 32]  = a;
        req_wdata[32*k +: 32] = d;
        req_strb[4*k +: 4]    = s;
        req_wren[k]         = w;
    endtask

    task automatic check_now();
        #2;
        model_eval();
        compare();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        model_commit();
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    int cnt0, cnt1;
    logic [N-1:0] served_prev;

    initial begin
        rst_n = 1'b0; req_valid = '0; req_addr = '0; req_wdata = '0;
        req_strb = '0; req_wren = '0; ready_in = 1'b0; ld_data = '0;

        // Reset state
        #2;
        chk("rst_busy",  32'(busy),      32'h0);
        chk("rst_valid", 32'(lsu_valid), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_rdata", req_rdata,      32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single-cycle load by master 0
        set_req(0, 1'b1, LEDR_ADDR, 32'h0, 4'hF, 1'b0);
        ready_in = 1'b1; ld_data = 32'h0000_03FF;
        check_now();
        chk("t1_ready", 32'(req_ready), 32'h1);
        chk("t1_rdata", req_rdata,      32'h0000_03FF);
        chk("t1_addr",  lsu_addr,       LEDR_ADDR);
        advance();

        // 2: both masters always valid, lsu always ready -> strict alternation,
        // starting with master 1 because the pointer moved past master 0.
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 8; i++) begin
            set_req(0, 1'b1, $urandom, $urandom, 4'(($urandom_range(0, 15))), 1'b0);
            set_req(1, 1'b1, $urandom, $urandom, 4'(($urandom_range(0, 15))), 1'b1);
            ld_data = $urandom;
            check_now();
            chk("t2_alt", 32'(req_ready), (i % 2 == 0) ? 32'h2 : 32'h1);
            if (req_ready == 2'b01) cnt0++;
            if (req_ready == 2'b10) cnt1++;
            advance();
        end
        chk("t2_share0", 32'(cnt0), 32'd4);
        chk("t2_share1", 32'(cnt1), 32'd4);

        // 3: master 1 store held for 3 wait cycles while master 0 waits
        set_req(1, 1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 4'b0011, 1'b1);
        set_req(0, 1'b1, 32'h0000_0200, 32'h0, 4'hF, 1'b0);
        for (int i = 0; i < 4; i++) begin
            ready_in = (i == 3);
            ld_data = 32'h1111_0000 + 32'(i);
            check_now();
            chk("t3_addr",  lsu_addr,       32'h0000_0100);
            chk("t3_data",  st_data,        32'hA5A5_A5A5);
            chk("t3_strb",  32'(st_strb),   32'h3);
            chk("t3_ready", 32'(req_ready), (i == 3) ? 32'h2 : 32'h0);
            advance();
        end
        set_req(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        check_now();
        chk("t3_next", 32'(req_ready), 32'h1);
        chk("t3_next_addr", lsu_addr, 32'h0000_0200);
        advance();
        set_req(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

        // 4: watchdog on a stuck load
        set_req(0, 1'b1, 32'h0000_0300, 32'h0, 4'hF, 1'b0);
        ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_now();
            if (i < 4) begin
                chk("t4_wait_ready", 32'(req_ready), 32'h0);
                chk("t4_wait_valid", 32'(lsu_valid), 32'h1);
            end else begin
                chk("t4_to_ready", 32'(req_ready), 32'h1);
                chk("t4_to_err",   32'(req_err),   32'h1);
                chk("t4_to_rdata", req_rdata,      32'hDEAD_BEEF);
                chk("t4_to_valid", 32'(lsu_valid), 32'h0);
            end
            advance();
        end
        set_req(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        check_now();
        chk("t4_idle", 32'(busy), 32'h0);
        advance();

        // 5: asynchronous reset while locked with wd_cnt=2
        set_req(1, 1'b1, 32'h0000_0400, 32'h0, 4'hF, 1'b0);
        ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_now();
            if (i == 2) begin
                rst_n = 1'b0;
                #1;
                chk("t5_valid", 32'(lsu_valid), 32'h0);
                chk("t5_busy",  32'(busy),      32'h0);
                chk("t5_ready", 32'(req_ready), 32'h0);
                own = -1; age = 0; rr = 0;
                exp_q.delete();
                @(negedge clk);
            end else begin
                advance();
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_req(0, 1'b1, 32'h0000_0500, 32'h0, 4'hF, 1'b0);
        ready_in = 1'b1; ld_data = 32'h5555_0000;
        check_now();
        chk("t5_prio", 32'(req_ready), 32'h1);
        advance();
        set_req(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        set_req(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

        // 6: READY arrives exactly at the timeout cycle
        set_req(0, 1'b1, 32'h0000_0600, 32'h0, 4'hF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            ready_in = (i == 4);
            ld_data = 32'hCAFE_0001;
            check_now();
            if (i == 4) begin
                chk("t6_ready", 32'(req_ready), 32'h1);
                chk("t6_err",   32'(req_err),   32'h0);
                chk("t6_rdata", req_rdata,      32'hCAFE_0001);
            end
            advance();
        end
        set_req(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        ready_in = 1'b0;

        // Random traffic with occasional abandoned requests and READY droughts
        served_prev = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int k = 0; k < N; k++) begin
                if (served_prev[k] || !req_valid[k]) begin
                    if ($urandom_range(0, 1) == 1)
                        set_req(k, 1'b1, $urandom, $urandom, 4'($urandom_range(0, 15)),
                                1'($urandom_range(0, 1)));
                    else
                        set_req(k, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
                end else if ($urandom_range(0, 63) == 0) begin
                    req_valid[k] = 1'b0;
                end
            end
            case ((cyc / 50) % 3)
                0:       ready_in = ($urandom_range(0, 9) < 7);
                1:       ready_in = ($urandom_range(0, 9) < 1);
                default: ready_in = 1'b0;
            endcase
            ld_data = $urandom;
            check_now();
            served_prev = e_ready;
            advance();
        end

        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
